// File: rtl/ea_divseq_if.sv
// Request/result bundle for the EA divide sequencer.
// The requester drives operands and flow control; the sequencer returns results.
interface ea_divseq_if #(
  parameter int W = 16
);
  logic           start;
  logic           sgn;
  logic           hold;
  logic           abort;
  logic [2*W-1:0] dvd;
  logic [W-1:0]   dvs;
  logic           busy;
  logic           done;
  logic [W-1:0]   quot;
  logic [W-1:0]   rem;
  logic           ovf;
  logic           dz;

  modport master (
    output start, sgn, hold, abort, dvd, dvs,
    input  busy, done, quot, rem, ovf, dz
  );

  modport slave (
    input  start, sgn, hold, abort, dvd, dvs,
    output busy, done, quot, rem, ovf, dz
  );
endinterface

// File: rtl/ea_divseq.sv
// Multi-cycle 2W/W restoring divider for the EA unit.
// Works on magnitudes, then applies signs and saturation in FIX.
module ea_divseq #(
  parameter int W = 16
) (
  input logic        DSPCLK,
  input logic        T_RST,
  ea_divseq_if.slave s_if
);
  localparam int CW = $clog2(W);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_ITER = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam logic [W-1:0] L_MIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] L_MAX = {1'b0, {(W-1){1'b1}}};

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_sgn;
  logic          r_sd;
  logic          r_ss;
  logic          r_ovfp;
  logic          r_dzp;
  logic [W-1:0]  r_pr;
  logic [W-1:0]  r_lo;
  logic [W-1:0]  r_dvs;
  logic [W-1:0]  r_quot;
  logic [W-1:0]  r_rem;
  logic          r_ovf;
  logic          r_dz;
  logic          r_done;

  // r_pr/r_lo hold the raw dividend until LOAD, then remainder/quotient
  logic [2*W-1:0] w_dvd;
  logic [2*W-1:0] w_dvdm;
  logic [W-1:0]   w_dvsm;
  logic           w_nd;
  logic           w_ns;

  assign w_dvd  = {r_pr, r_lo};
  assign w_nd   = r_sgn & r_pr[W-1];
  assign w_ns   = r_sgn & r_dvs[W-1];
  assign w_dvdm = w_nd ? -w_dvd : w_dvd;
  assign w_dvsm = w_ns ? -r_dvs : r_dvs;

  logic [W:0]   w_t;
  logic         w_ge;
  logic [W-1:0] w_d;

  assign w_t  = {r_pr, r_lo[W-1]};
  assign w_ge = w_t >= {1'b0, r_dvs};
  assign w_d  = w_t[W-1:0] - r_dvs;

  logic         w_qs;
  logic         w_sov;
  logic         w_ov;
  logic [W-1:0] w_sat;
  logic [W-1:0] w_q;
  logic [W-1:0] w_r;

  assign w_qs  = r_sgn & (r_sd ^ r_ss);
  assign w_sov = r_sgn & (w_qs ? (r_lo > L_MIN)
                               : (r_lo > L_MAX));
  assign w_ov  = r_ovfp | w_sov;
  assign w_sat = r_sgn ? (w_qs ? L_MIN : L_MAX)
                       : {W{1'b1}};
  assign w_q   = w_ov ? w_sat
                      : (w_qs ? -r_lo : r_lo);
  assign w_r   = w_ov ? '0
                      : ((r_sgn & r_sd) ? -r_pr : r_pr);

  always_ff @(posedge DSPCLK) begin
    if (T_RST) begin
      r_state <= S_IDLE;
      r_quot  <= '0;
      r_rem   <= '0;
      r_ovf   <= 1'b0;
      r_dz    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state != S_IDLE && s_if.abort) begin
        r_state <= S_IDLE;
      end else if (r_state == S_IDLE) begin
        if (s_if.start) begin
          r_sgn   <= s_if.sgn;
          r_pr    <= s_if.dvd[2*W-1:W];
          r_lo    <= s_if.dvd[W-1:0];
          r_dvs   <= s_if.dvs;
          r_state <= S_LOAD;
        end
      end else if (!s_if.hold) begin
        case (r_state)
          S_LOAD: begin
            r_sd    <= w_nd;
            r_ss    <= w_ns;
            r_pr    <= w_dvdm[2*W-1:W];
            r_lo    <= w_dvdm[W-1:0];
            r_dvs   <= w_dvsm;
            r_ovfp  <= w_dvdm[2*W-1:W] >= w_dvsm;
            r_dzp   <= w_dvsm == '0;
            r_cnt   <= CW'(W-1);
            r_state <= S_ITER;
          end
          S_ITER: begin
            r_pr <= w_ge ? w_d : w_t[W-1:0];
            r_lo <= {r_lo[W-2:0], w_ge};
            if (r_cnt == '0) r_state <= S_FIX;
            else r_cnt <= r_cnt - 1'b1;
          end
          S_FIX: begin
            r_quot  <= w_q;
            r_rem   <= w_r;
            r_ovf   <= w_ov;
            r_dz    <= r_dzp;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign s_if.busy = r_state != S_IDLE;
  assign s_if.done = r_done;
  assign s_if.quot = r_quot;
  assign s_if.rem  = r_rem;
  assign s_if.ovf  = r_ovf;
  assign s_if.dz   = r_dz;
endmodule

// File: tb/tb_ea_divseq.sv
// Scoreboard bench for ea_divseq: directed plan cases plus random
// operands, checked against a plain-arithmetic division model.
module tb_ea_divseq;
  localparam int W = 16;

  logic DSPCLK = 1'b0;
  logic T_RST  = 1'b1;

  ea_divseq_if #(.W(W)) dif ();

  ea_divseq #(.W(W)) dut (
    .DSPCLK(DSPCLK),
    .T_RST (T_RST),
    .s_if  (dif)
  );

  always #5 DSPCLK = ~DSPCLK;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         ov;
    logic         dz;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_tot  = 0;
  int   cyc    = 0;

  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;
  logic         last_ov = 1'b0;
  logic         last_dz = 1'b0;

  always @(posedge DSPCLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                  nm, act, exp, cyc);
  endtask

  // Reference: exact integer division, then range/saturation rules.
  function automatic exp_t model(input logic s,
                                 input logic [2*W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t   e;
    longint na, nb, q, r, hi;
    logic [W-1:0] mx, mn;
    mx = {1'b0, {(W-1){1'b1}}};
    mn = {1'b1, {(W-1){1'b0}}};
    e.cyc = 0;
    e.dz  = (b == '0);
    e.ov  = 1'b0;
    e.q   = '0;
    e.r   = '0;
    if (s) begin
      na = longint'($signed(a));
      nb = longint'($signed(b));
    end else begin
      na = longint'(a);
      nb = longint'(b);
    end
    if (b == '0) begin
      e.ov = 1'b1;
      e.q  = s ? ((na < 0) ? mn : mx) : '1;
    end else begin
      q  = na / nb;
      r  = na % nb;
      hi = longint'(1) << (s ? W - 1 : W);
      if (s) e.ov = (q > hi - 1) || (q < -hi);
      else   e.ov = q > hi - 1;
      if (e.ov) e.q = s ? ((q < 0) ? mn : mx) : '1;
      else begin
        e.q = W'(q);
        e.r = W'(r);
      end
    end
    return e;
  endfunction

  exp_t me;
  always @(negedge DSPCLK) begin
    if (!T_RST && dif.done) begin
      if (sb.size() == 0) begin
        chk("done_unexpected", dif.done, 0);
      end else begin
        me = sb.pop_front();
        chk("quot", dif.quot, me.q);
        chk("rem", dif.rem, me.r);
        chk("ovf", dif.ovf, me.ov);
        chk("dz", dif.dz, me.dz);
        chk("done_cycle", cyc, me.cyc);
        chk("busy_at_done", dif.busy, 0);
        last_q  = me.q;
        last_r  = me.r;
        last_ov = me.ov;
        last_dz = me.dz;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (dif.busy && n < 100) begin
      @(negedge DSPCLK);
      n++;
    end
    if (dif.busy) chk("idle_timeout", dif.busy, 0);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge DSPCLK);
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  // Called at a negedge with the DUT idle; returns one negedge after accept.
  task automatic issue(input logic s, input logic [2*W-1:0] a,
                       input logic [W-1:0] b, input bit push,
                       input int hd, input int hn);
    exp_t e;
    e = model(s, a, b);
    e.cyc = cyc + W + 3 + hn;
    if (push) sb.push_back(e);
    dif.start = 1'b1;
    dif.sgn   = s;
    dif.dvd   = a;
    dif.dvs   = b;
    @(negedge DSPCLK);
    dif.start = 1'b0;
    dif.sgn   = ~s;
    dif.dvd   = {$urandom, $urandom};
    dif.dvs   = W'($urandom);
    if (hn > 0) begin
      repeat (hd) @(negedge DSPCLK);
      dif.hold = 1'b1;
      repeat (hn) @(negedge DSPCLK);
      dif.hold = 1'b0;
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"}, dif.busy, 0);
    chk({nm, "_done"}, dif.done, 0);
    chk({nm, "_quot"}, dif.quot, 0);
    chk({nm, "_rem"}, dif.rem, 0);
    chk({nm, "_ovf"}, dif.ovf, 0);
    chk({nm, "_dz"}, dif.dz, 0);
  endtask

  typedef struct {
    logic           s;
    logic [2*W-1:0] a;
    logic [W-1:0]   b;
  } op_t;

  op_t dir[$] = '{
    '{1'b0, 32'h000186A0, 16'h0007},
    '{1'b1, 32'hFFFFFF9C, 16'h0007},
    '{1'b1, 32'hFFFF8000, 16'h0001},
    '{1'b1, 32'h00008000, 16'h0001},
    '{1'b0, 32'h00008000, 16'h0001},
    '{1'b0, 32'h00010000, 16'h0001},
    '{1'b1, 32'h00000005, 16'h0000},
    '{1'b1, 32'hFFFFFFFB, 16'h0000},
    '{1'b0, 32'h00000005, 16'h0000},
    '{1'b1, 32'h80000000, 16'hFFFF},
    '{1'b1, 32'hC0000000, 16'h8000},
    '{1'b1, 32'h3FFF8000, 16'h8000},
    '{1'b0, 32'hFFFEFFFF, 16'hFFFF},
    '{1'b1, 32'h00000064, 16'hFFF9}
  };

  initial begin
    logic [W-1:0] pq, pr;
    logic         pov, pdz;
    int           n0;
    logic         s;
    logic [2*W-1:0] a;
    logic [W-1:0] b;
    int           hn;

    dif.start = 1'b0;
    dif.sgn   = 1'b0;
    dif.hold  = 1'b0;
    dif.abort = 1'b0;
    dif.dvd   = '0;
    dif.dvs   = '0;
    repeat (3) @(negedge DSPCLK);
    chk_zero("reset");
    T_RST = 1'b0;
    @(negedge DSPCLK);

    foreach (dir[i]) begin
      wait_idle();
      issue(dir[i].s, dir[i].a, dir[i].b, 1'b1, 0, 0);
      drain();
      if (i == 0) begin
        chk("tp1_quot", last_q, 16'h37CD);
        chk("tp1_rem", last_r, 16'h0005);
      end
    end

    // hold for three cycles during ITER
    wait_idle();
    issue(1'b0, 32'h000186A0, 16'h0007, 1'b1, 3, 3);
    drain();

    // second start while busy must be ignored
    wait_idle();
    issue(1'b1, 32'hFFFFFF9C, 16'h0007, 1'b1, 0, 0);
    repeat (4) @(negedge DSPCLK);
    dif.start = 1'b1;
    @(negedge DSPCLK);
    dif.start = 1'b0;
    drain();
    repeat (25) @(negedge DSPCLK);
    chk("ignored_start_busy", dif.busy, 0);

    // abort five clocks after accept
    pq  = last_q;
    pr  = last_r;
    pov = last_ov;
    pdz = last_dz;
    wait_idle();
    issue(1'b0, 32'h12345678, 16'h0003, 1'b0, 0, 0);
    repeat (4) @(negedge DSPCLK);
    dif.abort = 1'b1;
    @(negedge DSPCLK);
    dif.abort = 1'b0;
    chk("abort_busy", dif.busy, 0);
    chk("abort_quot", dif.quot, pq);
    chk("abort_rem", dif.rem, pr);
    chk("abort_ovf", dif.ovf, pov);
    chk("abort_dz", dif.dz, pdz);
    repeat (25) @(negedge DSPCLK);

    // reset in the middle of ITER
    issue(1'b0, 32'h000186A0, 16'h0007, 1'b0, 0, 0);
    repeat (6) @(negedge DSPCLK);
    T_RST = 1'b1;
    @(negedge DSPCLK);
    chk_zero("midrst");
    T_RST = 1'b0;
    @(negedge DSPCLK);
    issue(1'b0, 32'h000186A0, 16'h0007, 1'b1, 0, 0);
    drain();

    // start held high: one accept every W+3 clocks
    wait_idle();
    n0 = cyc;
    for (int k = 0; k < 3; k++) begin
      me = model(1'b1, 32'hFFFFFF9C, 16'h0007);
      me.cyc = n0 + W + 3 + k * (W + 3);
      sb.push_back(me);
    end
    dif.start = 1'b1;
    dif.sgn   = 1'b1;
    dif.dvd   = 32'hFFFFFF9C;
    dif.dvs   = 16'h0007;
    repeat (2 * (W + 3) + 2) @(negedge DSPCLK);
    dif.start = 1'b0;
    drain();

    // randomized operands, occasional holds
    for (int i = 0; i < 150; i++) begin
      s = 1'($urandom);
      case ($urandom_range(0, 3))
        0: a = {16'h0000, 16'($urandom)};
        1: a = {16'hFFFF, 16'($urandom)};
        default: a = {$urandom};
      endcase
      case ($urandom_range(0, 7))
        0: b = '0;
        1, 2: b = W'($urandom_range(1, 15));
        default: b = W'($urandom);
      endcase
      hn = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      wait_idle();
      issue(s, a, b, 1'b1, $urandom_range(0, 10), hn);
      drain();
    end

    repeat (5) @(negedge DSPCLK);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
    $fatal(1);
  end
endmodule

// File: doc/ea_divseq.md
Name: ea_divseq

Overview:
- Parametrised multi-cycle divide sequencer for the EA (ALU) execution unit.
- Replaces the single-step DIVS/DIVQ programmer sequence: one `start` runs a complete 2W/W signed or unsigned division to quotient and true remainder.
- Fixed latency, hold (pipeline stall) input, and overflow and divide-by-zero detection.
- Results feed the AY0/AF update paths in the EA register block.

Parameters:
- W, 16, divisor/quotient/remainder width; dividend is 2W bits; W >= 4.

Ports:
- DSPCLK  in  1  system clock; all state updates on the rising edge.
- T_RST  in  1  synchronous active-high reset.
- start  in  1  request; sampled only in IDLE.
- sgn  in  1  1 = two's-complement operands, 0 = unsigned; captured with start.
- hold  in  1  freeze sequencer (GO_E stall); registers keep their values.
- abort  in  1  cancel the operation in progress.
- dvd  in  2W  dividend; captured on start.
- dvs  in  W  divisor; captured on start.
- busy  out  1  high from the start-accept edge until done is asserted.
- done  out  1  one-cycle pulse; results are valid with it and held until the next accept.
- quot  out  W  quotient.
- rem  out  W  remainder.
- ovf  out  1  quotient not representable (includes divide-by-zero).
- dz  out  1  divisor == 0.

Behaviour:
- Reset (T_RST=1, sync, highest priority, also mid-operation):
  - state=IDLE.
  - busy=0, done=0, quot=0, rem=0, ovf=0, dz=0.
- States: IDLE -> LOAD -> ITER (W cycles, counter W-1..0) -> FIX -> IDLE.
- IDLE:
  - start=1 at edge k: capture sgn/dvd/dvs, busy=1, go to LOAD.
  - start while busy is ignored; no queuing.
- LOAD (1 cycle):
  - Form magnitudes |dvd| (2W-bit unsigned) and |dvs| (W-bit unsigned). The most negative dvd maps to 2^(2W-1).
  - Record sign bits.
  - Pre-check: set ovf_pre if |dvd|[2W-1:W] >= |dvs|. This covers dvs=0, and sets dz.
- ITER:
  - One restoring step per cycle on the magnitudes, using a W+1-bit partial remainder; shift in one quotient bit, MSB first.
  - Runs all W cycles even when ovf_pre is set.
- FIX (1 cycle):
  - Quotient sign = sgn & (sign(dvd) ^ sign(dvs)).
  - Remainder takes the sign of dvd (truncation toward zero).
  - Signed overflow: negative quotient with magnitude > 2^(W-1), or positive quotient with magnitude > 2^(W-1)-1.
- Outputs at the FIX->IDLE edge: quot, rem, ovf, dz, done=1, busy=0.
- Latency: done is high in the cycle starting W+2 edges after the accept edge, plus one per hold cycle.
- Overflow results:
  - quot saturates. Signed: 0x7FF..F if the quotient sign is positive, else 0x800..0. Unsigned: all ones.
  - rem = 0.
- Divide by zero:
  - dz=1, ovf=1.
  - Signed: quot = 0x7FF..F if dvd >= 0, else 0x800..0. Unsigned: all ones.
  - rem = 0.
- hold=1: state, counter and datapath freeze; done cannot assert while hold=1; busy remains 1.
- abort=1 in any non-IDLE state:
  - Next state is IDLE; busy=0 at the next edge; no done.
  - quot/rem/ovf/dz keep their previous values.
  - abort has priority over hold; abort in IDLE has no effect.
- start and abort high together in IDLE: start is accepted.
- The edge that asserts done returns to IDLE; a new start can be accepted at the following edge.
- Inputs dvd/dvs/sgn may change after the accept edge without affecting the result.

Test Plan:
1. Unsigned, W=16: dvd=0x000186A0 (100000), dvs=7, sgn=0 -> done 18 clocks after accept; quot=0x37CD (14285), rem=0x0005, ovf=0, dz=0.
2. Signed: dvd=0xFFFFFF9C (-100), dvs=0x0007, sgn=1 -> quot=0xFFF2 (-14), rem=0xFFFE (-2). Also dvd=0xFFFF8000, dvs=1 -> quot=0x8000, ovf=0.
3. Overflow:
   - dvd=0x00008000, dvs=1, sgn=1 -> ovf=1, quot=0x7FFF, rem=0.
   - Same operands with sgn=0 -> quot=0x8000, ovf=0.
   - dvd=0x00010000, dvs=1, sgn=0 -> ovf=1, quot=0xFFFF.
4. Divide by zero:
   - dvd=5, dvs=0, sgn=1 -> dz=1, ovf=1, quot=0x7FFF, rem=0.
   - dvd=0xFFFFFFFB, sgn=1 -> quot=0x8000.
5. Flow control:
   - Test 1 with hold=1 for 3 cycles during ITER -> done at 21 clocks, identical result.
   - Second start pulsed while busy -> ignored.
   - abort 5 clocks after accept -> busy=0 next edge, no done, previous results unchanged.
6. Reset and back-to-back:
   - T_RST mid-ITER -> all outputs 0 at the next edge.
   - New start after reset -> correct result, latency 18.
   - start held high continuously -> operations accepted every 19 clocks.
